// File: rtl/vga_pkg.sv
// Shared timing defaults, coordinate types and helpers for the VGA timing/overlay generator.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 3;

    // Raw counter width on the pins, and the wider width used for window arithmetic
    localparam int CNT_W   = 10;
    localparam int COORD_W = 11;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic inwin;
        logic hit;
        logic frame_start;
    } stage_flags_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Half-open membership test: value in [lo, lo+len)
    function automatic logic in_span(input coord_t value, input coord_t lo, input coord_t len);
        return (value >= lo) && (value < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping axis counter 0..TOTAL-1; wrap flags the last count of an enabled step.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL    = 800,
    parameter int CNT_BITS = clog2(TOTAL)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Enable,
    output logic [CNT_BITS-1:0] count,
    output logic                wrap
);

    assign wrap = Enable && (count == CNT_BITS'(TOTAL - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (Enable) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_overlay_gen.sv
// Programmable VGA timing generator with border/sprite/image compositing, 2-cycle registered pipeline.
module vga_timing_overlay_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = DEF_COLOR_W,
    parameter int IMG_X0    = 240,
    parameter int IMG_Y0    = 141,
    parameter int IMG_W     = 256,
    parameter int IMG_H     = 256,
    parameter int SPR_W     = 32,
    parameter int SPR_H     = 32,
    parameter int POS_W     = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [COLOR_W-1:0]        iPixelRGB,
    input  logic [COLOR_W-1:0]        iSprColor,
    input  logic [POS_W-1:0]          iSprX,
    input  logic [POS_W-1:0]          iSprY,
    input  logic                      iSprEnable,
    input  logic [COLOR_W-1:0]        iBorderColor,
    output logic [COLOR_W-1:0]        oVGA_RGB,
    output logic                      oHsync,
    output logic                      oVsync,
    output logic                      oDataEnable,
    output logic                      oFrameStart,
    output logic [CNT_W-1:0]          oHcounter,
    output logic [CNT_W-1:0]          oVcounter,
    output logic [clog2(IMG_W)-1:0]   oPixelX,
    output logic [clog2(IMG_H)-1:0]   oPixelY,
    output logic                      oPixelValid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int PX_W    = clog2(IMG_W);
    localparam int PY_W    = clog2(IMG_H);

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    logic             h_wrap;
    logic             v_wrap;

    vga_axis_counter #(.TOTAL(H_TOTAL), .CNT_BITS(CNT_W)) u_h_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (1'b1),
        .count  (h_count),
        .wrap   (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .CNT_BITS(CNT_W)) u_v_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (h_wrap),
        .count  (v_count),
        .wrap   (v_wrap)
    );

    // Sprite shadow: v_wrap is only true on the very last pixel of the frame
    logic [POS_W-1:0] spr_x_q;
    logic [POS_W-1:0] spr_y_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            spr_x_q <= '0;
            spr_y_q <= '0;
        end else if (v_wrap) begin
            spr_x_q <= iSprX;
            spr_y_q <= iSprY;
        end
    end

    coord_t       h_c;
    coord_t       v_c;
    coord_t       spr_x0;
    coord_t       spr_y0;
    stage_flags_t s0;
    stage_flags_t s1;

    assign h_c    = coord_t'(h_count);
    assign v_c    = coord_t'(v_count);
    assign spr_x0 = coord_t'(IMG_X0) + coord_t'(spr_x_q);
    assign spr_y0 = coord_t'(IMG_Y0) + coord_t'(spr_y_q);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        s0             = '0;
        s0.active      = (h_c < coord_t'(H_ACTIVE)) && (v_c < coord_t'(V_ACTIVE));
        s0.hsync       = in_span(h_c, coord_t'(H_ACTIVE + H_FP), coord_t'(H_SYNC));
        s0.vsync       = in_span(v_c, coord_t'(V_ACTIVE + V_FP), coord_t'(V_SYNC));
        s0.inwin       = in_span(h_c, coord_t'(IMG_X0), coord_t'(IMG_W)) &&
                         in_span(v_c, coord_t'(IMG_Y0), coord_t'(IMG_H));
        s0.hit         = in_span(h_c, spr_x0, coord_t'(SPR_W)) &&
                         in_span(v_c, spr_y0, coord_t'(SPR_H));
        s0.frame_start = (h_count == '0) && (v_count == '0);
    end

    assign oPixelX     = PX_W'(h_c - coord_t'(IMG_X0));
    assign oPixelY     = PY_W'(v_c - coord_t'(IMG_Y0));
    assign oPixelValid = s0.inwin;
    assign oHcounter   = h_count;
    assign oVcounter   = v_count;

    // NOTE: pipeline flags are asynchronously cleared so a reset mid-line cannot leave stale pulses.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s1 <= '0;
        end else begin
            s1 <= s0;
        end
    end

    logic [COLOR_W-1:0] rgb_next;

    always_comb begin
        rgb_next = '0;
        if (!s1.active) begin
            rgb_next = '0;
        end else if (!s1.inwin) begin
            rgb_next = iBorderColor;
        end else if (s1.hit && iSprEnable) begin
            rgb_next = iSprColor;
        end else begin
            rgb_next = iPixelRGB;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            oVGA_RGB    <= '0;
            oHsync      <= ~HSYNC_POL;
            oVsync      <= ~VSYNC_POL;
            oDataEnable <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oVGA_RGB    <= rgb_next;
            oHsync      <= s1.hsync ? HSYNC_POL : ~HSYNC_POL;
            oVsync      <= s1.vsync ? VSYNC_POL : ~VSYNC_POL;
            oDataEnable <= s1.active;
            oFrameStart <= s1.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_timing_overlay_gen.sv
// Bench for vga_timing_overlay_gen on a shrunken raster: per-cycle reference model plus directed literals.
module tb_vga_timing_overlay_gen;

    localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int X0 = 10, Y0 = 5, IW = 32, IH = 32, SW = 8, SH = 8;
    localparam bit HPOL = 1'b0, VPOL = 1'b0;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] iPixelRGB, iSprColor, iBorderColor;
    logic [4:0] iSprX, iSprY;
    logic       iSprEnable;
    logic [2:0] oVGA_RGB;
    logic       oHsync, oVsync, oDataEnable, oFrameStart, oPixelValid;
    logic [9:0] oHcounter, oVcounter;
    logic [4:0] oPixelX, oPixelY;

    vga_timing_overlay_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .COLOR_W(3),
        .IMG_X0(X0), .IMG_Y0(Y0), .IMG_W(IW), .IMG_H(IH),
        .SPR_W(SW), .SPR_H(SH), .POS_W(5)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .iPixelRGB(iPixelRGB), .iSprColor(iSprColor), .iSprX(iSprX), .iSprY(iSprY),
        .iSprEnable(iSprEnable), .iBorderColor(iBorderColor),
        .oVGA_RGB(oVGA_RGB), .oHsync(oHsync), .oVsync(oVsync), .oDataEnable(oDataEnable),
        .oFrameStart(oFrameStart), .oHcounter(oHcounter), .oVcounter(oVcounter),
        .oPixelX(oPixelX), .oPixelY(oPixelY), .oPixelValid(oPixelValid)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_win(input int h, input int v);
        return (h >= X0) && (h < X0 + IW) && (v >= Y0) && (v < Y0 + IH);
    endfunction

    function automatic logic [2:0] model_rgb(input int h, input int v, input int sx, input int sy,
                                             input logic en, input logic [2:0] sc,
                                             input logic [2:0] bc, input logic [2:0] px);
        if (!(h < HA && v < VA)) return 3'b000;
        if (!in_win(h, v)) return bc;
        if (en && h >= X0 + sx && h < X0 + sx + SW && v >= Y0 + sy && v < Y0 + sy + SH) return sc;
        return px;
    endfunction

    // k = cycles since reset release; shadow_* = sprite position in force for each frame index
    int k;
    bit tracking = 1'b0;
    int shadow_x[32];
    int shadow_y[32];
    int mh, mv, ch, cv, cf;

    always @(posedge Clock) begin
        #1;
        if (tracking) begin
            k = k + 1;
            if (k % FRAME == 0 && k / FRAME < 32) begin
                shadow_x[k / FRAME] = int'(iSprX);
                shadow_y[k / FRAME] = int'(iSprY);
            end
            mh = k % HT;
            mv = (k / HT) % VT;
            check("hcounter", oHcounter, mh);
            check("vcounter", oVcounter, mv);
            check("pixel_valid", oPixelValid, in_win(mh, mv));
            check("pixel_x", oPixelX, (mh - X0) & (IW - 1));
            check("pixel_y", oPixelY, (mv - Y0) & (IH - 1));
            if (k == 1) begin
                check("rgb_first", oVGA_RGB, 0);
                check("hsync_first", oHsync, !HPOL);
                check("vsync_first", oVsync, !VPOL);
                check("de_first", oDataEnable, 0);
                check("fs_first", oFrameStart, 0);
            end else begin
                ch = (k - 2) % HT;
                cv = ((k - 2) / HT) % VT;
                cf = ((k - 2) / FRAME) % 32;
                check("rgb", oVGA_RGB, model_rgb(ch, cv, shadow_x[cf], shadow_y[cf],
                                                 iSprEnable, iSprColor, iBorderColor, iPixelRGB));
                check("hsync", oHsync, (ch >= HA + HFP && ch < HA + HFP + HS) ? HPOL : !HPOL);
                check("vsync", oVsync, (cv >= VA + VFP && cv < VA + VFP + VS) ? VPOL : !VPOL);
                check("data_enable", oDataEnable, (ch < HA && cv < VA));
                check("frame_start", oFrameStart, (ch == 0 && cv == 0));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_at(input int h, input int v, input string name);
        int n;
        bit found;
        n = 0;
        found = 1'b0;
        while (!found && n < FRAME + 4) begin
            @(posedge Clock);
            #1;
            n++;
            if (oHcounter == 10'(h) && oVcounter == 10'(v)) found = 1'b1;
        end
        check({"reach_", name}, found, 1);
    endtask

    task automatic expect_pin(input int h, input int v, input logic [2:0] exp, input string name);
        wait_at(h, v, name);
        repeat (2) begin
            @(posedge Clock);
            #1;
        end
        check(name, oVGA_RGB, exp);
    endtask

    task automatic drive_sprite(input int x, input int y);
        @(negedge Clock);
        iSprX = 5'(x);
        iSprY = 5'(y);
    endtask

    task automatic restart_model();
        k = 0;
        for (int i = 0; i < 32; i++) begin
            shadow_x[i] = 0;
            shadow_y[i] = 0;
        end
        tracking = 1'b1;
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            iPixelRGB = 3'($urandom);
            if ($urandom_range(63) == 0) iSprColor = 3'($urandom);
            if ($urandom_range(63) == 0) iBorderColor = 3'($urandom);
            if ($urandom_range(1999) == 0) iSprEnable = ~iSprEnable;
            if ($urandom_range(499) == 0) begin
                iSprX = 5'($urandom);
                iSprY = 5'($urandom);
            end
        end
    endtask

    // ---------------- main sequence ----------------
    int hlow, vlow, first_hlow, first_vlow, fs_count, first_fs;

    initial begin
        Reset = 1'b1;
        iPixelRGB = 3'b001;
        iSprColor = 3'b100;
        iBorderColor = 3'b010;
        iSprEnable = 1'b1;
        iSprX = 5'd2;
        iSprY = 5'd3;

        repeat (5) begin
            @(posedge Clock);
            #1;
            check("hsync_in_reset", oHsync, 1);
            check("vsync_in_reset", oVsync, 1);
        end
        check("rgb_in_reset", oVGA_RGB, 0);
        check("de_in_reset", oDataEnable, 0);

        @(negedge Clock);
        Reset = 1'b0;
        restart_model();
        #1;
        check("hcount_after_release", oHcounter, 0);

        // Frame 0: sync windows, frame-start pulse, line wrap
        hlow = 0; vlow = 0; first_hlow = -1; first_vlow = -1; fs_count = 0; first_fs = -1;
        for (int i = 1; i <= FRAME; i++) begin
            @(posedge Clock);
            #1;
            if (i <= HT && !oHsync) begin
                hlow++;
                if (first_hlow < 0) first_hlow = i;
            end
            if (!oVsync) begin
                vlow++;
                if (first_vlow < 0) first_vlow = i;
            end
            if (oFrameStart) begin
                fs_count++;
                if (first_fs < 0) first_fs = i;
            end
            if (i == HT) begin
                check("hcount_one_line", oHcounter, 0);
                check("vcount_one_line", oVcounter, 1);
            end
        end
        check("hsync_low_len", hlow, HS);
        check("hsync_low_start", first_hlow, HA + HFP + 2);
        check("vsync_low_len", vlow, VS * HT);
        check("vsync_low_start", first_vlow, (VA + VFP) * HT + 2);
        check("fs_pulses", fs_count, 1);
        check("fs_position", first_fs, 2);

        // Frame 1: shadow (2,3) -> sprite at H 12..19, V 8..15
        expect_pin(9, 8, 3'b010, "border_left");
        expect_pin(12, 8, 3'b100, "spr_left_edge");
        wait_at(19, 8, "spr_right");
        repeat (2) begin
            @(posedge Clock);
            #1;
        end
        check("spr_right_edge", oVGA_RGB, 3'b100);
        @(posedge Clock);
        #1;
        check("img_after_spr", oVGA_RGB, 3'b001);
        expect_pin(64, 8, 3'b000, "blank_after_active");
        wait_at(0, 10, "mid_frame_move");
        drive_sprite(12, 3);
        expect_pin(12, 12, 3'b100, "spr_held_old_x");
        expect_pin(22, 12, 3'b001, "new_x_not_yet");
        expect_pin(12, 15, 3'b100, "spr_bottom_row");
        expect_pin(12, 16, 3'b001, "below_spr");

        // Frame 2: new position takes effect
        expect_pin(12, 12, 3'b001, "old_x_gone");
        expect_pin(22, 12, 3'b100, "new_x_live");
        wait_at(0, 20, "clip_move");
        drive_sprite(28, 3);

        // Frame 3: sprite H 38..45 clipped at window edge 42
        expect_pin(41, 12, 3'b100, "spr_clip_inside");
        expect_pin(42, 13, 3'b010, "spr_clip_border");
        expect_pin(45, 14, 3'b010, "spr_clip_far");
        wait_at(0, 15, "disable");
        @(negedge Clock);
        iSprEnable = 1'b0;
        expect_pin(41, 15, 3'b001, "spr_disabled");
        @(negedge Clock);
        iSprEnable = 1'b1;

        random_cycles(4 * FRAME);

        // Asynchronous reset mid-line
        wait_at(30, 20, "pre_reset");
        check("de_before_reset", oDataEnable, 1);
        @(negedge Clock);
        tracking = 1'b0;
        Reset = 1'b1;
        #1;
        check("async_rst_hcount", oHcounter, 0);
        check("async_rst_vcount", oVcounter, 0);
        check("async_rst_rgb", oVGA_RGB, 0);
        check("async_rst_de", oDataEnable, 0);
        check("async_rst_fs", oFrameStart, 0);
        check("async_rst_hsync", oHsync, 1);
        check("async_rst_vsync", oVsync, 1);
        repeat (3) begin
            @(posedge Clock);
            #1;
            check("hsync_held_reset", oHsync, 1);
        end
        @(negedge Clock);
        Reset = 1'b0;
        restart_model();
        #1;
        check("restart_h0", oHcounter, 0);
        @(posedge Clock);
        #1;
        check("restart_h1", oHcounter, 1);
        @(posedge Clock);
        #1;
        check("restart_h2", oHcounter, 2);

        random_cycles(FRAME + 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vga_timing_overlay_gen.md
Name: vga_timing_overlay_gen

Overview:
- Parametrised VGA timing generator and pixel compositor; successor to the fixed 640x480 controller.
- Produces programmable-porch H/V timing with selectable sync polarity, data-enable and frame-start strobe, plus an image-relative fetch address.
- Composites, in priority order: blanking, a border around an image window, a movable sprite, and the fetched image pixel.
- Sprite position is double-buffered per frame; outputs are fully registered through a 2-stage pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch (lines)
- HSYNC_POL / VSYNC_POL, 0 / 0, active level of sync (0 = active-low)
- COLOR_W, 3, bits per pixel colour
- IMG_X0 / IMG_Y0, 240 / 141, image window origin in counter coordinates
- IMG_W / IMG_H, 256 / 256, image window size
- SPR_W / SPR_H, 32 / 32, sprite size
- POS_W, 8, sprite position width (relative to image origin)

Ports:
- Clock  in  1  pixel clock
- Reset  in  1  asynchronous, active-high reset
- iPixelRGB  in  COLOR_W  image pixel for the address presented one cycle earlier
- iSprColor  in  COLOR_W  sprite colour
- iSprX / iSprY  in  POS_W  sprite top-left offset from image origin
- iSprEnable  in  1  sprite visible
- iBorderColor  in  COLOR_W  colour of active area outside the image window
- oVGA_RGB  out  COLOR_W  registered pixel output
- oHsync / oVsync  out  1  registered sync outputs
- oDataEnable  out  1  registered; high during active video
- oFrameStart  out  1  one-cycle pulse; first active pixel of the frame is on the pins
- oHcounter / oVcounter  out  10  raw counter values
- oPixelX / oPixelY  out  log2(IMG_W) / log2(IMG_H)  image fetch address (counter − origin, truncated)
- oPixelValid  out  1  counters lie inside the image window

Behaviour:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800). V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
- Line order: active, front porch, sync, back porch.
- H counter runs 0..H_TOTAL−1 and wraps to 0. V counter increments when H = H_TOTAL−1 and wraps after V_TOTAL−1.
- Stage 0 (combinational from counters):
  - active = (H < H_ACTIVE) && (V < V_ACTIVE)
  - hsync asserted for H in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync is analogous on V
  - inwin = H in [IMG_X0, IMG_X0+IMG_W) && V in [IMG_Y0, IMG_Y0+IMG_H)
  - sprite hit = H in [IMG_X0+sx, IMG_X0+sx+SPR_W) && V in [IMG_Y0+sy, IMG_Y0+sy+SPR_H); all ranges half-open, arithmetic at 11 bits with no overflow
  - oPixelX, oPixelY and oPixelValid are driven from this stage.
- Stage 1: register active, sync, inwin, hit, and the frame-start condition (H=0, V=0).
- Stage 2: register outputs. Colour select, highest priority first:
  - !active → 0
  - !inwin → iBorderColor
  - hit && iSprEnable → iSprColor
  - otherwise iPixelRGB
- Sync pins are driven at the POL level when asserted, ~POL otherwise.
- Latency: counters to pins = 2 cycles. iPixelRGB is sampled 1 cycle after its address.
- Sprite shadow: sx/sy are loaded from iSprX/iSprY only when H = H_TOTAL−1 && V = V_TOTAL−1. Mid-frame input changes have no visible effect until the next frame.
- Clipping: a sprite extending past the window edge shows border (inwin has priority).
- Reset (asynchronous):
  - counters and shadows = 0
  - oVGA_RGB = 0, oDataEnable = 0, oFrameStart = 0
  - syncs at the inactive level
  - pipeline valid flags cleared
  - counting restarts from 0 on the first edge after deassertion
  - Reset mid-line aborts the frame with no glitch pulses.

Decomposition:
- Shared package vga_pkg: default 640x480@60 timing constants, COLOR_W, and a clog2 helper.
- Sub-module vga_axis_counter, instantiated twice: parameter TOTAL; inputs Clock, Reset, Enable; outputs count and wrap (count = TOTAL−1 && Enable). The V instance is enabled by the H wrap.

Test Plan:
- Release Reset, run 800 clocks → oHcounter=0, oVcounter=1. Run 420000 clocks from release → exactly one oFrameStart pulse, 2 cycles after counters = (0,0).
- Defaults, sync timing → oHsync low for exactly 96 consecutive clocks starting 2 cycles after H=656. oVsync low for 2 lines starting at V=490. Syncs stay high throughout reset.
- iSprX=10, iSprY=20, iSprColor=3'b100, iPixelRGB=3'b001, iBorderColor=3'b010:
  - counter H=250..281, V=161..192 → pins 100
  - H=282 → 001
  - H=239 → 010
  - H=640 → 000
  - each observed 2 cycles later
- Change iSprX 10→50 while V=200 → sprite stays at H=250 for the rest of the frame and appears at H=290 from the next frame.
- iSprX=240 → sprite visible at H=480..495 only; H=496..511 in sprite rows shows border 010.
- Assert Reset at H=300, V=100 → all outputs take reset values immediately, without waiting for a clock edge. After deassertion, oHcounter counts 0,1,2…
